// File: rtl/mp_cycle_controller.sv
// mp_cycle_controller
// Multi-cycle control sequencer for the 16-bit MicroProcessor datapath.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and
// produces per-phase enables from the single system clock. Data-memory waits
// are bounded by MEM_TIMEOUT; a timeout latches mem_err and parks in HALT.
// Optional feature macro: MP_SINGLE_STEP_EN (single-step start from IDLE).
module mp_cycle_controller #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clock,
   input  logic             clr_n,
   input  logic             run,
   input  logic             step,
   input  logic [3:0]       opcode,
   input  logic             zero,
   input  logic             dmem_ready,
   output logic             ir_load,
   output logic             alu_en,
   output logic             pc_inc,
   output logic             pc_load,
   output logic             dmem_rd,
   output logic             dmem_wr,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             halted,
   output logic             mem_err,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FETCH     = 3'd1;
   localparam logic [2:0] S_DECODE    = 3'd2;
   localparam logic [2:0] S_EXECUTE   = 3'd3;
   localparam logic [2:0] S_MEMORY    = 3'd4;
   localparam logic [2:0] S_WRITEBACK = 3'd5;
   localparam logic [2:0] S_HALT      = 3'd6;

   // Last wait-counter value before the timeout fires (counter would reach MEM_TIMEOUT)
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   logic [2:0]       state_reg, state_next;
   logic [7:0]       wait_reg;
   logic [CNT_W-1:0] count_reg;
   logic             err_reg;

   // Opcode classes
   logic is_alu, is_load, is_store, is_beq, is_jump, is_halt, is_short;
   logic start, after_retire, retire, take_branch, timeout;

   assign is_alu   = (opcode >= 4'h1) && (opcode <= 4'h7);
   assign is_load  = (opcode == 4'h8);
   assign is_store = (opcode == 4'h9);
   assign is_beq   = (opcode == 4'hA);
   assign is_jump  = (opcode == 4'hB);
   assign is_halt  = (opcode == 4'hF);
   // NOP, BEQ, JUMP and the NOP-like 0xC..0xE finish in EXECUTE
   assign is_short = !(is_alu || is_load || is_store);

`ifdef MP_SINGLE_STEP_EN
   // A step in IDLE launches one instruction; it returns to IDLE unless run is set
   assign start = run | step;
`else
   // step has no effect in this build; the term reduces to run
   assign start = run | (run & step);
`endif

   assign after_retire = run;

   assign retire = ((state_reg == S_EXECUTE) && is_short) ||
                   ((state_reg == S_MEMORY) && is_store && dmem_ready) ||
                   (state_reg == S_WRITEBACK);

   assign take_branch = is_jump || (is_beq && zero);

   // Ready has priority over the timeout in the same cycle
   assign timeout = (state_reg == S_MEMORY) && !dmem_ready && (wait_reg == WAIT_LAST);

   // State register
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) state_next = S_FETCH;
         end
         S_FETCH: begin
            state_next = S_DECODE;
         end
         S_DECODE: begin
            state_next = is_halt ? S_HALT : S_EXECUTE;
         end
         S_EXECUTE: begin
            if (is_alu)
               state_next = S_WRITEBACK;
            else if (is_load || is_store)
               state_next = S_MEMORY;
            else
               state_next = after_retire ? S_FETCH : S_IDLE;
         end
         S_MEMORY: begin
            if (dmem_ready) begin
               if (is_load)
                  state_next = S_WRITEBACK;
               else
                  state_next = after_retire ? S_FETCH : S_IDLE;
            end else if (timeout) begin
               state_next = S_HALT;
            end
         end
         S_WRITEBACK: begin
            state_next = after_retire ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            state_next = S_HALT;
         end
         default: begin
            state_next = S_HALT;
         end
      endcase
   end

   // Wait counter, sticky timeout flag and saturating retire counter
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         wait_reg  <= '0;
         err_reg   <= 1'b0;
         count_reg <= '0;
      end else begin
         if (state_reg != S_MEMORY)
            wait_reg <= '0;
         else if (!dmem_ready)
            wait_reg <= wait_reg + 8'd1;
         if (timeout)
            err_reg <= 1'b1;
         if (retire && (count_reg != {CNT_W{1'b1}}))
            count_reg <= count_reg + 1'b1;
      end
   end

   // Output decode from registered state, qualified in the retire cycle
   always_comb begin
      ir_load    = 1'b0;
      alu_en     = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      dmem_rd    = 1'b0;
      dmem_wr    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      halted     = 1'b0;
      case (state_reg)
         S_FETCH:     ir_load = 1'b1;
         S_EXECUTE:   alu_en  = 1'b1;
         S_MEMORY: begin
            dmem_rd = is_load;
            dmem_wr = is_store;
         end
         S_WRITEBACK: begin
            reg_write  = 1'b1;
            mem_to_reg = is_load;
         end
         S_HALT:      halted = 1'b1;
         default: ;
      endcase
      if (retire) begin
         pc_load = take_branch;
         pc_inc  = !take_branch;
      end
   end

   assign mem_err     = err_reg;
   assign state       = state_reg;
   assign instr_count = count_reg;

endmodule

// File: tb/tb_mp_cycle_controller.sv
// Directed testbench for mp_cycle_controller (default parameters).
// Expected values are hand-computed from the instruction timing.
module tb_mp_cycle_controller;

   logic        clock = 1'b0;
   logic        clr_n = 1'b0;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic [3:0]  opcode = 4'h0;
   logic        zero = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        ir_load, alu_en, pc_inc, pc_load, dmem_rd, dmem_wr;
   logic        reg_write, mem_to_reg, halted, mem_err;
   logic [2:0]  state;
   logic [15:0] instr_count;

   int total = 0;
   int bad = 0;

   mp_cycle_controller #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
      .clock(clock), .clr_n(clr_n), .run(run), .step(step), .opcode(opcode),
      .zero(zero), .dmem_ready(dmem_ready), .ir_load(ir_load), .alu_en(alu_en),
      .pc_inc(pc_inc), .pc_load(pc_load), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted),
      .mem_err(mem_err), .state(state), .instr_count(instr_count)
   );

   always #5 clock = ~clock;

   // Advance one clock and land 2 time units after the rising edge
   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 3-cycle instruction (NOP/BEQ/JUMP class) launched from IDLE, ending in IDLE
   task automatic short_instr(input logic [3:0] op, input logic z, input logic exp_load,
                              input logic [15:0] exp_cnt);
      opcode = op;
      run = 1'b1;
      cyc();
      chk("short_fetch_state", 32'(state), 32'd1);
      run = 1'b0;
      cyc();
      chk("short_decode_state", 32'(state), 32'd2);
      cyc();
      zero = z;
      #1;
      chk("short_exec_alu_en", 32'(alu_en), 32'd1);
      chk("short_exec_pc_load", 32'(pc_load), 32'(exp_load));
      chk("short_exec_pc_inc", 32'(pc_inc), 32'(!exp_load));
      zero = 1'b0;
      cyc();
      chk("short_idle_state", 32'(state), 32'd0);
      chk("short_count", 32'(instr_count), 32'(exp_cnt));
      $display("short instr op=%h zero=%0b count=%0d", op, z, instr_count);
   endtask

   initial begin
      logic [2:0] alu_seq [4];
      int wr_cycles;
      alu_seq[0] = 3'd1; alu_seq[1] = 3'd2; alu_seq[2] = 3'd3; alu_seq[3] = 3'd5;

      // Reset state
      cyc();
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_count", 32'(instr_count), 32'd0);
      chk("reset_err", 32'(mem_err), 32'd0);
      chk("reset_ir_load", 32'(ir_load), 32'd0);
      clr_n = 1'b1;
      opcode = 4'h1;
      run = 1'b1;
      #1;
      chk("post_release_state", 32'(state), 32'd0);
      chk("post_release_ir_load", 32'(ir_load), 32'd0);
      $display("reset released");

      // ALU stream: 1,2,3,5 repeating; reg_write only in WRITEBACK
      for (int i = 0; i < 12; i++) begin
         cyc();
         chk("alu_state", 32'(state), 32'(alu_seq[i % 4]));
         chk("alu_reg_write", 32'(reg_write), 32'((i % 4) == 3));
      end
      cyc();
      chk("alu_count_3", 32'(instr_count), 32'd3);
      chk("alu_refetch", 32'(state), 32'd1);
      $display("alu stream count=%0d", instr_count);
      run = 1'b0;
      cyc();
      cyc();
      cyc();
      chk("alu_wb_reg_write", 32'(reg_write), 32'd1);
      chk("alu_wb_pc_inc", 32'(pc_inc), 32'd1);
      chk("alu_wb_mem_to_reg", 32'(mem_to_reg), 32'd0);
      cyc();
      chk("alu_stop_idle", 32'(state), 32'd0);
      chk("alu_count_4", 32'(instr_count), 32'd4);

      // LOAD with two wait cycles
      opcode = 4'h8;
      run = 1'b1;
      cyc();
      chk("load_ir_load", 32'(ir_load), 32'd1);
      run = 1'b0;
      cyc();
      cyc();
      chk("load_exec_pc_inc", 32'(pc_inc), 32'd0);
      cyc();
      chk("load_mem1_rd", 32'(dmem_rd), 32'd1);
      chk("load_mem1_wr", 32'(dmem_wr), 32'd0);
      cyc();
      chk("load_mem2_rd", 32'(dmem_rd), 32'd1);
      cyc();
      dmem_ready = 1'b1;
      #1;
      chk("load_mem3_rd", 32'(dmem_rd), 32'd1);
      chk("load_mem3_no_pc", 32'(pc_inc), 32'd0);
      cyc();
      dmem_ready = 1'b0;
      #1;
      chk("load_wb_state", 32'(state), 32'd5);
      chk("load_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
      chk("load_wb_reg_write", 32'(reg_write), 32'd1);
      chk("load_wb_pc_inc", 32'(pc_inc), 32'd1);
      cyc();
      chk("load_count", 32'(instr_count), 32'd5);
      $display("load retired count=%0d", instr_count);

      // BEQ taken, BEQ not taken, JUMP
      short_instr(4'hA, 1'b1, 1'b1, 16'd6);
      short_instr(4'hA, 1'b0, 1'b0, 16'd7);
      short_instr(4'hB, 1'b0, 1'b1, 16'd8);

      // STORE that never sees ready: timeout after 15 MEMORY cycles
      opcode = 4'h9;
      run = 1'b1;
      cyc();
      run = 1'b0;
      cyc();
      cyc();
      wr_cycles = 0;
      for (int i = 0; i < 15; i++) begin
         cyc();
         if (dmem_wr) wr_cycles++;
      end
      chk("store_wr_cycles", 32'(wr_cycles), 32'd15);
      chk("store_still_mem", 32'(state), 32'd4);
      cyc();
      chk("timeout_state", 32'(state), 32'd6);
      chk("timeout_halted", 32'(halted), 32'd1);
      chk("timeout_err", 32'(mem_err), 32'd1);
      chk("timeout_wr_off", 32'(dmem_wr), 32'd0);
      chk("timeout_count", 32'(instr_count), 32'd8);
      run = 1'b1;
      cyc();
      cyc();
      chk("timeout_sticky", 32'(state), 32'd6);
      $display("store timeout err=%0b state=%0d", mem_err, state);
      clr_n = 1'b0;
      #1;
      chk("async_rst_state", 32'(state), 32'd0);
      chk("async_rst_err", 32'(mem_err), 32'd0);
      chk("async_rst_count", 32'(instr_count), 32'd0);
      cyc();
      clr_n = 1'b1;

      // HALT opcode
      opcode = 4'hF;
      cyc();
      cyc();
      chk("halt_decode_no_pc", 32'(pc_inc), 32'd0);
      cyc();
      chk("halt_state", 32'(state), 32'd6);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_err_clear", 32'(mem_err), 32'd0);
      chk("halt_count", 32'(instr_count), 32'd0);
      $display("halt opcode state=%0d", state);
      clr_n = 1'b0;
      #1;
      chk("halt_rst_state", 32'(state), 32'd0);
      cyc();
      clr_n = 1'b1;

      // Reset mid-EXECUTE of the second ALU instruction
      opcode = 4'h1;
      for (int i = 0; i < 7; i++) cyc();
      chk("mid_exec_state", 32'(state), 32'd3);
      chk("mid_exec_count", 32'(instr_count), 32'd1);
      clr_n = 1'b0;
      #1;
      chk("mid_rst_state", 32'(state), 32'd0);
      chk("mid_rst_count", 32'(instr_count), 32'd0);
      chk("mid_rst_alu_en", 32'(alu_en), 32'd0);
      cyc();
      chk("mid_rst_no_pc", 32'(pc_inc), 32'd0);
      run = 1'b0;
      clr_n = 1'b1;
      $display("reset mid-execute state=%0d", state);

      // Single step from IDLE
      step = 1'b1;
      cyc();
`ifdef MP_SINGLE_STEP_EN
      chk("step_start", 32'(state), 32'd1);
`else
      chk("step_start", 32'(state), 32'd0);
`endif
      step = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      chk("step_end_state", 32'(state), 32'd0);
`ifdef MP_SINGLE_STEP_EN
      chk("step_count", 32'(instr_count), 32'd1);
`else
      chk("step_count", 32'(instr_count), 32'd0);
`endif
      $display("single step count=%0d", instr_count);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mp_cycle_controller.md
# mp_cycle_controller

Multi-cycle control sequencer for the 16-bit MicroProcessor datapath. It replaces the free-running divided PC clock with per-phase enables derived from the single system clock. It steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, handles data-memory wait states with a timeout, supports run/halt control, and counts retired instructions. It sits between the instruction register opcode field and the PC, register file, ALU and data-memory enables.

## Interface
Parameters:
- MEM_TIMEOUT, 15: max MEMORY-state cycles waiting for dmem_ready before error (1..255)
- CNT_W, 16: width of retired-instruction counter

Ports:
- clock  in  1  system clock, all state on rising edge
- clr_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = free-run instructions
- step  in  1  single-step request (only with MP_SINGLE_STEP_EN)
- opcode  in  4  inst[15:12] from IR, stable from DECODE to retire
- zero  in  1  ALU zero flag, sampled in EXECUTE
- dmem_ready  in  1  data memory access complete
- ir_load  out  1  load IR from instruction memory
- alu_en  out  1  ALU operands/result valid
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= branch/jump target
- dmem_rd  out  1  data memory read request
- dmem_wr  out  1  data memory write request
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback mux selects memory data
- halted  out  1  controller in HALT
- mem_err  out  1  sticky memory-timeout flag
- state  out  3  current state encoding
- instr_count  out  CNT_W  retired instructions, saturating

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6. Code 7 is illegal and goes to HALT with mem_err unchanged.
- Opcode classes: 0x0 NOP; 0x1–0x7 ALU; 0x8 LOAD; 0x9 STORE; 0xA BEQ; 0xB JUMP; 0xC–0xE treated as NOP; 0xF HALT.
- IDLE → FETCH when run=1.
- FETCH (ir_load=1) → DECODE.
- DECODE → HALT if opcode=0xF, else → EXECUTE.
- EXECUTE: alu_en=1.
  - ALU → WRITEBACK.
  - LOAD/STORE → MEMORY.
  - NOP/BEQ/JUMP retire here.
- MEMORY: dmem_rd=1 (LOAD) or dmem_wr=1 (STORE), held every cycle until dmem_ready=1.
  - LOAD with ready → WRITEBACK.
  - STORE retires on the ready cycle.
- WRITEBACK: reg_write=1; mem_to_reg=1 iff LOAD; retires.
- Retire cycle:
  - pc_load=1 for JUMP, or for BEQ with zero=1; otherwise pc_inc=1. pc_inc and pc_load are never both 1.
  - instr_count increments, saturating at all-ones.
  - Next state is FETCH if run=1, else IDLE.
- Wait counter: cleared on MEMORY entry, increments each MEMORY cycle without ready. If it reaches MEM_TIMEOUT without ready: mem_err←1, → HALT, no retire, no PC update.
- HALT: halted=1, all enables 0, sticky until clr_n. HALT opcode does not retire and does not count.
- All enables are Moore decodes of registered state, plus opcode/zero/dmem_ready qualification in the retire cycle. Enables are 0 in IDLE and HALT.

## Timing
- Reset (clr_n=0, asynchronous): state=IDLE, instr_count=0, mem_err=0, wait counter=0. All outputs 0 while reset is held and in the first cycle after release.
- Latency from FETCH to retire:
  - NOP/BEQ/JUMP: 3 cycles
  - ALU: 4 cycles
  - STORE: 4+w cycles
  - LOAD: 5+w cycles
  - w = wait cycles before dmem_ready
- dmem_ready is ignored outside MEMORY. A ready in the first MEMORY cycle gives w=0.
- run deasserted mid-instruction: the instruction completes, then the controller goes to IDLE.
- Reset asserted mid-instruction: immediate abort. No retire or PC pulse follows.
- Simultaneous dmem_ready and timeout: ready wins.

## Configuration
- MP_SINGLE_STEP_EN defined:
  - In IDLE, step=1 with run=0 starts exactly one instruction; after retire, return to IDLE.
  - step outside IDLE is ignored.
  - step held high starts one instruction per visit to IDLE.
- Undefined: the step port exists but is ignored; only run starts execution.

## Test plan
- Reset then run=1, opcode=0x1 held: state sequence 1,2,3,5,1…; reg_write pulses 1 cycle per 4; instr_count=3 after 12 cycles from first FETCH.
- LOAD (0x8) with dmem_ready after 2 wait cycles: dmem_rd high 3 cycles, then WRITEBACK with mem_to_reg=1, reg_write=1; retire 7 cycles after FETCH.
- BEQ (0xA): zero=1 → pc_load=1, pc_inc=0 in EXECUTE; zero=0 → pc_inc=1, pc_load=0; 3-cycle instruction.
- STORE (0x9) with dmem_ready never asserted, MEM_TIMEOUT=15: dmem_wr high 15 cycles; then mem_err=1, halted=1, state=6; instr_count unchanged until clr_n.
- HALT opcode 0xF: DECODE → HALT, halted=1, no pc_inc; clr_n pulse mid-EXECUTE of a later run returns state=0 and instr_count=0 asynchronously.
- With MP_SINGLE_STEP_EN, run=0, one step pulse on ALU opcode: exactly one retire, then IDLE; instr_count=1. Without the macro, the same stimulus leaves state=0.
